// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the wait-state data memory
//
// Purpose : FSM state encoding, default base address and lane/offset helpers
//           used by wait_state_data_memory and dmem_byte_ram.
// Ports   : none (package).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] MEMORY_START_POSITION = 32'd1024;

    // Number of byte lanes in a word.
    function automatic int lanes_f(input int dw);
        return dw / 8;
    endfunction

    // Number of byte-offset bits below the word index.
    function automatic int ofs_f(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// rtl/dmem_byte_ram.sv - word array with per-byte-lane synchronous write
//
// Purpose : DEPTH x DATA_WIDTH storage, no reset (contents survive reset).
// Ports   : clk_i   - clock
//           we_i    - write strobe for this edge
//           idx_i   - word index for both write and combinational read
//           be_i    - byte-lane enables, bit l covers wdata_i[8l+7:8l]
//           wdata_i - write data
//           rdata_o - combinational read of mem[idx_i]
module dmem_byte_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IW         = 6
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IW-1:0]           idx_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (be_i[l]) begin
                    mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/wait_state_data_memory.sv
// rtl/wait_state_data_memory.sv - MEM-stage data memory with configurable wait states
//
// Purpose : Accepts one read/write request from IDLE, stalls WAIT_CYCLES
//           cycles, then pulses ready for one cycle with registered read
//           data and an address-error flag. Range/alignment checked.
// Ports   : clk      - clock, posedge
//           rst      - synchronous active-low reset
//           MEM_r_en - read request
//           MEM_w_en - write request (wins over MEM_r_en)
//           address  - byte address
//           data_in  - write data
//           byte_en  - write byte-lane enables
//           data_out - registered read data (0 for writes/illegal)
//           ready    - one-cycle completion pulse
//           addr_err - illegal completed access, valid with ready
module wait_state_data_memory
    import mem_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = MEMORY_START_POSITION,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_r_en,
    input  logic                    MEM_w_en,
    input  logic [31:0]             address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    ready,
    output logic                    addr_err
);

    localparam int LANES = lanes_f(DATA_WIDTH);
    localparam int OFS   = ofs_f(DATA_WIDTH);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CNT_LOAD  = CW'(WAIT_CYCLES);
    localparam logic [31:0]   LANE_MASK = 32'(LANES - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [LANES-1:0]        be_q;
    logic                    write_q;
    logic                    illegal_q;
    logic [DATA_WIDTH-1:0]   dout_q;

    logic [31:0]             off;
    logic [31:0]             idx_full;
    logic                    live_illegal;
    logic                    req;
    logic                    in_idle;
    logic                    enter_done;

    logic [IW-1:0]           acc_idx;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [LANES-1:0]        acc_be;
    logic                    acc_write;
    logic                    acc_illegal;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    // Range and alignment check on the live request; wrap-around of the
    // 32-bit subtraction is caught by the explicit below-base compare.
    assign off          = address - BASE_ADDR;
    assign idx_full     = off >> OFS;
    assign live_illegal = (address < BASE_ADDR)
                        | (idx_full >= 32'(DEPTH))
                        | ((off & LANE_MASK) != 32'd0);

    assign req     = MEM_r_en | MEM_w_en;
    assign in_idle = (state_q == IDLE);

    // With zero wait states DONE is entered straight from IDLE, before the
    // request has been latched, so the commit uses the live request then.
    assign acc_idx     = in_idle ? idx_full[IW-1:0] : idx_q;
    assign acc_wdata   = in_idle ? data_in          : wdata_q;
    assign acc_be      = in_idle ? byte_en          : be_q;
    assign acc_write   = in_idle ? MEM_w_en         : write_q;
    assign acc_illegal = in_idle ? live_illegal     : illegal_q;

    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign ram_we     = enter_done & acc_write & ~acc_illegal & rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_idle && req) begin
                idx_q     <= idx_full[IW-1:0];
                wdata_q   <= data_in;
                be_q      <= byte_en;
                write_q   <= MEM_w_en;
                illegal_q <= live_illegal;
            end
            if (enter_done) begin
                dout_q <= (acc_write || acc_illegal) ? '0 : ram_rdata;
            end
        end
    end

    dmem_byte_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .idx_i   (acc_idx),
        .be_i    (acc_be),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    assign data_out = dout_q;
    assign ready    = (state_q == DONE);
    assign addr_err = ready & illegal_q;

endmodule

// File: doc/wait_state_data_memory.md
Name: wait_state_data_memory

Overview:
Parametrised data memory for the MEM stage.
- Configurable data width, depth, base address and access latency (wait states).
- Per-byte write enables and address-range/alignment checking.
- A `ready` handshake so the pipeline freezes while an access is in flight.
- Replaces the fixed 64-word, zero-latency data memory; the core freezes on `(MEM_r_en | MEM_w_en) & ~ready`.

Parameters:
- DATA_WIDTH, 32: word width in bits; power of 2, ≥8.
- DEPTH, 64: number of words.
- BASE_ADDR, 32'd1024: byte address of word 0.
- WAIT_CYCLES, 1: extra stall cycles per access; 0 gives the minimum latency of 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- MEM_r_en  in  1  read request.
- MEM_w_en  in  1  write request.
- address  in  32  byte address.
- data_in  in  DATA_WIDTH  write data.
- byte_en  in  DATA_WIDTH/8  write byte-lane enables; bit i covers bits [8i+7:8i].
- data_out  out  DATA_WIDTH  read data, registered.
- ready  out  1  access complete; one-cycle pulse.
- addr_err  out  1  completed access was illegal; valid only with `ready`.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, counter=0, ready=0, data_out=0, addr_err=0.
  - Memory contents are not cleared.
  - Reset during BUSY aborts the access. An uncommitted write is discarded and the location is unchanged.
- Derived values:
  - LANES = DATA_WIDTH/8; OFS = log2(LANES).
  - off = address - BASE_ADDR, computed in 32 bits.
  - index = off >> OFS.
- Illegal access, any of:
  - address < BASE_ADDR;
  - index ≥ DEPTH;
  - off[OFS-1:0] ≠ 0 (misaligned).
- State machine states: IDLE, BUSY, DONE.
  - IDLE: if MEM_r_en|MEM_w_en, latch address, data_in, byte_en, op and the illegal flag.
    - Load counter = WAIT_CYCLES.
    - Go to BUSY if WAIT_CYCLES>0, otherwise DONE.
    - ready=0.
  - BUSY: decrement counter. When the counter reaches 1 (or 0 on entry), next state is DONE. ready=0.
  - DONE: ready=1 for exactly this cycle, then return to IDLE.
    - A request still asserted in the following IDLE cycle is treated as a new access. The requester must drop or change the enables after seeing ready.
- Latency:
  - Request first seen in IDLE at cycle t → ready=1 in cycle t+WAIT_CYCLES+1.
  - ready=0 at all other times.
- Simultaneous r_en and w_en: treated as a write; data_out is driven to 0.
- Write commit:
  - Performed on the edge entering DONE, and only for lanes with byte_en=1.
  - Suppressed if illegal.
  - A read accepted in the cycle after DONE returns the new data.
- Read: data_out is loaded with mem[index] on the edge entering DONE and held until the next accepted request's DONE.
  - Illegal read or write: data_out=0.
- addr_err:
  - Equals the latched illegal flag in the DONE cycle; 0 otherwise.
  - An illegal access still completes with normal latency and never hangs.
- Enables dropping or address changing during BUSY: ignored; the latched request completes.
- Counter width is clog2(WAIT_CYCLES+1), minimum 1.

Decomposition:
- Shared package `mem_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - MEMORY_START_POSITION default constant (1024);
  - localparam helpers for LANES/OFS.
- One sub-module: `dmem_byte_ram` (DEPTH × DATA_WIDTH array, per-lane write enable, synchronous write, combinational read indexed by latched index).
- Top level holds the FSM, counter, range check and output registers.

Test Plan:
All scenarios use DATA_WIDTH=32, DEPTH=64, BASE_ADDR=1024, WAIT_CYCLES=2 unless stated.
1. Write 0xDEADBEEF to 1028 with byte_en=4'hF, then read 1028 → ready pulses at t+3 for each access; read returns data_out=0xDEADBEEF, addr_err=0.
2. After scenario 1, write 0x0000AA00 to 1028 with byte_en=4'b0010, then read → data_out=0xDEADAAEF.
3. Accesses to 1020, 1280 and 1030 → each gives ready at t+3 with addr_err=1 and data_out=0; a read of 1024..1276 afterwards shows every word unchanged.
4. Write 0x12345678 to 1100, then a read of 1100 accepted in the cycle right after DONE → 0x12345678. Also both enables high at 1104 with data 0x5 → treated as a write; a later read of 1104 returns 5.
5. Assert rst=0 in the first BUSY cycle of a write of 0xFFFFFFFF to 1032 (pre-loaded with 0x11111111) → next cycle ready=0, data_out=0, state IDLE; a later read of 1032 returns 0x11111111.
6. Build with WAIT_CYCLES=0 and DATA_WIDTH=64 → ready at t+1; write then read at 1024+8·63=1528 round-trips correctly; address 1536 gives addr_err=1.
